// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI monarch (master) block.
// The SCLK divider values give 16-clk half periods of SCLK.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FRONT_PORCH,
    SHIFT,
    BACK_PORCH
  } spi_state_t;

  // Reload value parks SCLK high, 9 clk before the first falling edge.
  localparam logic [4:0] SCLK_DIV_INIT = 5'b10111;
  localparam logic [4:0] SCLK_SMPL     = 5'b10001;
  localparam logic [4:0] SCLK_SHFT     = 5'b11111;

endpackage

// File: rtl/spi_mnrch.sv
// SPI monarch: 16-bit full-duplex transaction per wrt pulse, SCLK = clk/32 idling high.
// One shift register carries MOSI data out and MISO data in.
module spi_mnrch
  import spi_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wrt,
  input  logic [15:0] cmd,
  input  logic        MISO,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  output logic        done,
  output logic [15:0] rd_data
);

  spi_state_t  state, nxt_state;
  logic [4:0]  SCLK_div;
  logic [15:0] shft_reg;
  logic [3:0]  bit_cnt;
  logic        MISO_smpl;

  logic        strt;
  logic        shft;
  logic        set_done;
  logic        smpl_evt;
  logic        shft_evt;

  assign smpl_evt = (state != IDLE) && (SCLK_div == SCLK_SMPL);
  assign shft_evt = (SCLK_div == SCLK_SHFT);

  // NOTE: every output of this block gets a default before the case, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    nxt_state = state;
    strt      = 1'b0;
    shft      = 1'b0;
    set_done  = 1'b0;
    case (state)
      IDLE: begin
        if (wrt) begin
          strt      = 1'b1;
          nxt_state = FRONT_PORCH;
        end
      end
      FRONT_PORCH: begin
        if (shft_evt) nxt_state = SHIFT;
      end
      SHIFT: begin
        if (shft_evt) begin
          shft = 1'b1;
          if (bit_cnt == 4'd14) nxt_state = BACK_PORCH;
        end
      end
      BACK_PORCH: begin
        // The 16th shift coincides with the reload, so SCLK never falls a 17th time.
        if (shft_evt) begin
          shft      = 1'b1;
          set_done  = 1'b1;
          nxt_state = IDLE;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                SCLK_div <= SCLK_DIV_INIT;
    else if (strt || set_done) SCLK_div <= SCLK_DIV_INIT;
    else if (state != IDLE)    SCLK_div <= SCLK_div + 5'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        bit_cnt <= 4'd0;
    else if (strt)                     bit_cnt <= 4'd0;
    else if (shft && state == SHIFT)   bit_cnt <= bit_cnt + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        MISO_smpl <= 1'b0;
    else if (smpl_evt) MISO_smpl <= MISO;
  end

  // NOTE: the shift register is a handful of flops, not a memory, so it is
  // reset along with the rest of the datapath and rd_data reads zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    shft_reg <= 16'h0000;
    else if (strt) shft_reg <= cmd;
    else if (shft) shft_reg <= {shft_reg[14:0], MISO_smpl};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      SS_n <= 1'b1;
      done <= 1'b0;
    end else if (strt) begin
      SS_n <= 1'b0;
      done <= 1'b0;
    end else if (set_done) begin
      SS_n <= 1'b1;
      done <= 1'b1;
    end
  end

  assign SCLK    = SCLK_div[4];
  assign MOSI    = shft_reg[15];
  assign rd_data = shft_reg;

endmodule

// File: tb/tb_spi_mnrch.sv
// Directed bench for spi_mnrch: stimulus pushes expected words, a done monitor
// pops and compares them together with latency and SS_n.
module tb_spi_mnrch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wrt = 1'b0;
  logic [15:0] cmd = 16'h0000;
  logic        MISO;
  logic        SS_n, SCLK, MOSI, done;
  logic [15:0] rd_data;

  spi_mnrch dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wrt     (wrt),
    .cmd     (cmd),
    .MISO    (MISO),
    .SS_n    (SS_n),
    .SCLK    (SCLK),
    .MOSI    (MOSI),
    .done    (done),
    .rd_data (rd_data)
  );

  always #5 clk = ~clk;

  typedef enum {LOOP, SLAVE, WINDOW} miso_mode_t;
  miso_mode_t  mode = LOOP;
  logic        slv_bit = 1'b0;
  logic        win_bit = 1'b0;
  logic [15:0] slave_word = 16'h0000;
  logic [3:0]  slv_idx = 4'd15;

  assign MISO = (mode == LOOP) ? MOSI : (mode == SLAVE) ? slv_bit : win_bit;

  int tests = 0;
  int fails = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bench slave: presents the next bit on each SCLK fall while selected.
  always @(negedge SCLK) begin
    if (!SS_n) begin
      slv_bit = slave_word[slv_idx];
      slv_idx = slv_idx - 4'd1;
    end
  end

  // SCLK rise observer: counts rises and records MOSI as the slave would sample it.
  int unsigned rise_total = 0;
  logic [15:0] mosi_bits = 16'h0000;
  always @(posedge SCLK) begin
    if (!SS_n) begin
      rise_total++;
      mosi_bits = {mosi_bits[14:0], MOSI};
    end
  end

  // Scoreboard
  typedef struct {
    logic [15:0] data;
    int unsigned start;
    string       name;
  } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;
  logic done_q = 1'b0;

  always @(negedge clk) begin
    if (rst_n && done && !done_q) begin
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done rise at cycle %0d expected none", cyc);
      end else begin
        mon_e = sb_q.pop_front();
        check({mon_e.name, "_rd_data"}, {16'h0, rd_data}, {16'h0, mon_e.data});
        check({mon_e.name, "_latency"}, cyc - mon_e.start, 32'd521);
        check({mon_e.name, "_ss_n_with_done"}, {31'h0, SS_n}, 32'd1);
      end
    end
    done_q = done;
  end

  int unsigned base_rise;

  // Caller is at a negedge; wrt is sampled on the following posedge.
  task automatic start_txn(input logic [15:0] c, input logic [15:0] expd,
                           input string name, input bit push);
    exp_t e;
    cmd = c;
    wrt = 1'b1;
    @(posedge clk);
    #1;
    base_rise = rise_total;
    if (push) begin
      e.data  = expd;
      e.start = cyc;
      e.name  = name;
      sb_q.push_back(e);
    end
    @(negedge clk);
    wrt = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (done) return;
    end
    tests++;
    fails++;
    $display("FAIL %s_timeout: got no done expected done within 600 clk", name);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  logic [15:0] pattern;
  int          k;
  int          ph;
  logic        prev_sclk;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ss_n",    {31'h0, SS_n}, 32'd1);
    check("rst_sclk",    {31'h0, SCLK}, 32'd1);
    check("rst_done",    {31'h0, done}, 32'd0);
    check("rst_rd_data", {16'h0, rd_data}, 32'h0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Loopback A55A
    mode = LOOP;
    start_txn(16'hA55A, 16'hA55A, "loop_a55a", 1'b1);
    wait_done("loop_a55a");
    check("loop_a55a_rises", rise_total - base_rise, 32'd16);
    check("loop_a55a_mosi",  {16'h0, mosi_bits}, 32'hA55A);
    repeat (10) @(negedge clk);
    check("loop_a55a_hold_rd", {16'h0, rd_data}, 32'hA55A);
    check("loop_a55a_hold_done", {31'h0, done}, 32'd1);
    check("loop_a55a_hold_sclk", {31'h0, SCLK}, 32'd1);

    // Bench slave returns 006A while 8F00 goes out
    mode = SLAVE;
    slave_word = 16'h006A;
    start_txn(16'h8F00, 16'h006A, "slave_006a", 1'b1);
    wait_done("slave_006a");
    check("slave_mosi",  {16'h0, mosi_bits}, 32'h8F00);
    check("slave_rises", rise_total - base_rise, 32'd16);
    repeat (4) @(negedge clk);

    // wrt with FFFF while busy must be ignored
    mode = LOOP;
    start_txn(16'h3C3C, 16'h3C3C, "busy_3c3c", 1'b1);
    repeat (200) @(negedge clk);
    cmd = 16'hFFFF;
    wrt = 1'b1;
    @(negedge clk);
    wrt = 1'b0;
    cmd = 16'h0000;
    wait_done("busy_3c3c");
    check("busy_rises", rise_total - base_rise, 32'd16);
    repeat (30) @(negedge clk);
    check("busy_no_restart_ss_n", {31'h0, SS_n}, 32'd1);
    check("busy_rd_stable", {16'h0, rd_data}, 32'h3C3C);

    // Back-to-back: wrt one clk after done
    start_txn(16'h5555, 16'h5555, "b2b_first", 1'b1);
    wait_done("b2b_first");
    start_txn(16'h1234, 16'h1234, "b2b_1234", 1'b1);
    check("b2b_done_clear", {31'h0, done}, 32'd0);
    check("b2b_ss_n_low",   {31'h0, SS_n}, 32'd0);
    wait_done("b2b_1234");
    repeat (4) @(negedge clk);

    // MISO valid only in the SCLK_div==10001 cycle, inverted at 10000 and 10010
    mode = WINDOW;
    pattern = 16'hC5A3;
    win_bit = ~pattern[15];
    start_txn(16'h0000, 16'hC5A3, "window_c5a3", 1'b1);
    k = 0;
    ph = 0;
    prev_sclk = SCLK;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #1;
      if (SCLK && !prev_sclk && k < 16) begin
        win_bit = ~pattern[15 - k];
        ph = 1;
      end else if (ph == 1) begin
        win_bit = pattern[15 - k];
        ph = 2;
      end else if (ph == 2) begin
        win_bit = ~pattern[15 - k];
        ph = 0;
        k++;
      end
      prev_sclk = SCLK;
      if (done) break;
    end
    check("window_bits_driven", k, 32'd16);
    @(negedge clk);
    repeat (4) @(negedge clk);

    // Reset in the middle of bit 7 aborts without done
    mode = LOOP;
    start_txn(16'hF0F0, 16'h0000, "abort", 1'b0);
    for (int i = 0; i < 600; i++) begin
      if (rise_total - base_rise >= 8) break;
      @(negedge clk);
    end
    check("abort_reached_bit7", rise_total - base_rise, 32'd8);
    repeat (20) @(negedge clk);
    check("abort_sclk_low_before", {31'h0, SCLK}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("abort_ss_n", {31'h0, SS_n}, 32'd1);
    check("abort_sclk", {31'h0, SCLK}, 32'd1);
    check("abort_done", {31'h0, done}, 32'd0);
    check("abort_rd_data", {16'h0, rd_data}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_done_after_release", {31'h0, done}, 32'd0);

    start_txn(16'h0F0F, 16'h0F0F, "post_abort", 1'b1);
    wait_done("post_abort");
    check("post_abort_rises", rise_total - base_rise, 32'd16);
    repeat (4) @(negedge clk);

    check("sb_empty", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
